// File: rtl/bin_pkg.sv
// Shared types and encodings for the multi-mode image binarizer.
// Used by the binarizer top level and the reusable classifier.
package bin_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SUM  = 3'd1,
      ST_CALC = 3'd2,
      ST_BIN  = 3'd3,
      ST_DONE = 3'd4
   } bin_state_t;

   localparam logic [1:0] MODE_FIXED = 2'd0;
   localparam logic [1:0] MODE_INV   = 2'd1;
   localparam logic [1:0] MODE_BAND  = 2'd2;
   localparam logic [1:0] MODE_MEAN  = 2'd3;

   localparam logic [1:0] LED_IDLE = 2'b00;
   localparam logic [1:0] LED_SUM  = 2'b01;
   localparam logic [1:0] LED_BIN  = 2'b10;
   localparam logic [1:0] LED_DONE = 2'b11;

   // Mode 3 runs a summing pass before binarizing; the others go straight to it.
   function automatic logic needs_sum_pass(input logic [1:0] mode);
      return (mode == MODE_MEAN);
   endfunction

endpackage

// File: rtl/bin_classify.sv
// Combinational pixel classifier: compares one grey pixel against the
// threshold(s) selected by the binarization mode.
module bin_classify
   import bin_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] pix,
   input  logic [PIX_W-1:0] thres_lo,
   input  logic [PIX_W-1:0] thres_hi,
   output logic             result
);

   // Mode 3 reuses the thres_lo input for the computed mean; an empty band yields 0.
   always_comb begin
      result = 1'b0;
      case (mode)
         MODE_FIXED: result = (pix >= thres_lo);
         MODE_INV:   result = (pix < thres_lo);
         MODE_BAND:  result = (pix >= thres_lo) && (pix <= thres_hi);
         MODE_MEAN:  result = (pix >= thres_lo);
         default:    result = 1'b0;
      endcase
   end

endmodule

// File: rtl/binarization_multi.sv
// Streams a grey frame from a synchronous RAM, classifies each pixel in one of
// four modes and writes one result bit per pixel to the binary frame buffer.
module binarization_multi
   import bin_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              bin_clk,
   input  logic              bin_rst_n,
   input  logic              bin_ctrl,
   input  logic [1:0]        bin_mode,
   input  logic [PIX_W-1:0]  thres_lo,
   input  logic [PIX_W-1:0]  thres_hi,
   output logic [ADDR_W-1:0] pixel_address,
   input  logic [PIX_W-1:0]  pixel_data,
   output logic [ADDR_W-1:0] bin_address,
   output logic              bin_data,
   output logic              bin_we,
   output logic [ADDR_W:0]   fg_count,
   output logic [PIX_W-1:0]  mean_thres,
   output logic [1:0]        condition_led
);

   localparam int SUM_W = PIX_W + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   bin_state_t        state_r;
   logic [1:0]        mode_r;
   logic [PIX_W-1:0]  thr_lo_r;
   logic [PIX_W-1:0]  thr_hi_r;
   logic              addr_act_r;
   logic              vld_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic [SUM_W-1:0]  sum_r;
   logic [ADDR_W:0]   fg_run_r;
   logic [PIX_W-1:0]  cls_lo_s;
   logic              cls_s;

   // Mode 3 compares against the computed mean instead of the latched low threshold.
   always_comb begin
      cls_lo_s = thr_lo_r;
      if (mode_r == MODE_MEAN) begin
         cls_lo_s = mean_thres;
      end else begin
         cls_lo_s = thr_lo_r;
      end
   end

   bin_classify #(
      .PIX_W (PIX_W)
   ) u_classify (
      .mode     (mode_r),
      .pix      (pixel_data),
      .thres_lo (cls_lo_s),
      .thres_hi (thr_hi_r),
      .result   (cls_s)
   );

   // Control FSM with address counter, read-valid pipeline, accumulator and counters.
   always_ff @(posedge bin_clk or negedge bin_rst_n) begin
      if (!bin_rst_n) begin
         state_r       <= ST_IDLE;
         mode_r        <= MODE_FIXED;
         thr_lo_r      <= {PIX_W{1'b0}};
         thr_hi_r      <= {PIX_W{1'b0}};
         addr_act_r    <= 1'b0;
         vld_r         <= 1'b0;
         rd_addr_r     <= {ADDR_W{1'b0}};
         sum_r         <= {SUM_W{1'b0}};
         fg_run_r      <= {(ADDR_W+1){1'b0}};
         pixel_address <= {ADDR_W{1'b0}};
         bin_address   <= {ADDR_W{1'b0}};
         bin_data      <= 1'b0;
         bin_we        <= 1'b0;
         fg_count      <= {(ADDR_W+1){1'b0}};
         mean_thres    <= {PIX_W{1'b0}};
         condition_led <= LED_IDLE;
      end else begin
         // Read data for the address issued last cycle is valid this cycle.
         vld_r     <= addr_act_r;
         rd_addr_r <= pixel_address;
         bin_we    <= 1'b0;
         if (addr_act_r) begin
            if (pixel_address == LAST_ADDR) begin
               addr_act_r <= 1'b0;
            end else begin
               pixel_address <= pixel_address + ADDR_ONE;
            end
         end

         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bin_ctrl) begin
                  mode_r        <= bin_mode;
                  thr_lo_r      <= thres_lo;
                  thr_hi_r      <= thres_hi;
                  sum_r         <= {SUM_W{1'b0}};
                  fg_run_r      <= {(ADDR_W+1){1'b0}};
                  pixel_address <= {ADDR_W{1'b0}};
                  addr_act_r    <= 1'b1;
                  if (needs_sum_pass(bin_mode)) begin
                     state_r       <= ST_SUM;
                     condition_led <= LED_SUM;
                  end else begin
                     state_r       <= ST_BIN;
                     condition_led <= LED_BIN;
                  end
               end
            end
            ST_SUM: begin
               if (vld_r) begin
                  sum_r <= sum_r + SUM_W'(pixel_data);
                  if (rd_addr_r == LAST_ADDR) begin
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               mean_thres    <= sum_r[SUM_W-1:ADDR_W];
               pixel_address <= {ADDR_W{1'b0}};
               addr_act_r    <= 1'b1;
               state_r       <= ST_BIN;
               condition_led <= LED_BIN;
            end
            ST_BIN: begin
               if (vld_r) begin
                  bin_we      <= 1'b1;
                  bin_data    <= cls_s;
                  bin_address <= rd_addr_r;
                  if (cls_s) begin
                     fg_run_r <= fg_run_r + CNT_ONE;
                  end
               end
               // The last write is on the bus now; its count is already in fg_run_r.
               if (bin_we && (bin_address == LAST_ADDR)) begin
                  fg_count      <= fg_run_r;
                  state_r       <= ST_DONE;
                  condition_led <= LED_DONE;
               end
            end
            default: begin
               addr_act_r    <= 1'b0;
               state_r       <= ST_IDLE;
               condition_led <= LED_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binarization_multi.sv
// Self-checking bench for binarization_multi: directed table, control/reset
// corner sequences and randomized frames against a behavioural model.
module tb_binarization_multi;

   localparam int PIX_W  = 8;
   localparam int ADDR_W = 4;
   localparam int N      = 16;

   logic              bin_clk = 1'b0;
   logic              bin_rst_n = 1'b0;
   logic              bin_ctrl = 1'b0;
   logic [1:0]        bin_mode = 2'd0;
   logic [PIX_W-1:0]  thres_lo = 8'd0;
   logic [PIX_W-1:0]  thres_hi = 8'd0;
   logic [ADDR_W-1:0] pixel_address;
   logic [PIX_W-1:0]  pixel_data;
   logic [ADDR_W-1:0] bin_address;
   logic              bin_data;
   logic              bin_we;
   logic [ADDR_W:0]   fg_count;
   logic [PIX_W-1:0]  mean_thres;
   logic [1:0]        condition_led;

   logic [PIX_W-1:0]  mem [N];

   int checks = 0;
   int errors = 0;

   // Results captured by run_frame
   logic [N-1:0] got_bits;
   int got_writes, first_we, done_cyc, busy, led_hist, fg_mid;

   binarization_multi #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
      .bin_clk       (bin_clk),
      .bin_rst_n     (bin_rst_n),
      .bin_ctrl      (bin_ctrl),
      .bin_mode      (bin_mode),
      .thres_lo      (thres_lo),
      .thres_hi      (thres_hi),
      .pixel_address (pixel_address),
      .pixel_data    (pixel_data),
      .bin_address   (bin_address),
      .bin_data      (bin_data),
      .bin_we        (bin_we),
      .fg_count      (fg_count),
      .mean_thres    (mean_thres),
      .condition_led (condition_led)
   );

   always #5 bin_clk = ~bin_clk;

   // Behavioural synchronous grey RAM
   always @(posedge bin_clk) pixel_data <= mem[pixel_address];

   typedef struct {
      logic [1:0] m;
      logic [7:0] lo;
      logic [7:0] hi;
      logic [15:0] bits;
      int fg;
      int mean;
      int first;
      int done;
      int leds;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic ref_bit(input logic [1:0] m, input int lo, input int hi,
                                    input int mean, input int p);
      case (m)
         2'd0:    return p >= lo;
         2'd1:    return p < lo;
         2'd2:    return (lo <= p) && (p <= hi);
         default: return p >= mean;
      endcase
   endfunction

   // Start a frame at cycle 0 and observe each following cycle until DONE.
   task automatic run_frame(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                            input int pert_cyc);
      logic [1:0] prev;
      got_bits = '0; got_writes = 0; first_we = -1; done_cyc = -1; busy = 0;
      led_hist = 0; fg_mid = -1;
      prev = condition_led;
      bin_mode = m; thres_lo = lo; thres_hi = hi; bin_ctrl = 1'b1;
      for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
         @(posedge bin_clk);
         @(negedge bin_clk);
         if (bin_we) begin
            got_bits[bin_address] = bin_data;
            got_writes++;
            if (first_we < 0) first_we = cyc;
         end
         if (condition_led != prev) begin
            led_hist = led_hist * 4 + int'(condition_led);
            prev = condition_led;
         end
         if (condition_led == 2'b01 || condition_led == 2'b10) busy++;
         if (condition_led == 2'b11) done_cyc = cyc;
         if (cyc == 5) fg_mid = int'(fg_count);
         bin_ctrl = (cyc == pert_cyc);
         if (cyc == pert_cyc) begin
            thres_lo = ~lo;
            bin_mode = m ^ 2'd1;
         end
      end
      bin_ctrl = 1'b0;
      if (done_cyc < 0) chk("frame_timeout", done_cyc, 0);
   endtask

   initial begin
      logic [N-1:0] exp_bits;
      int exp_fg, exp_mean, sum;
      logic [1:0] rm;
      logic [7:0] rlo, rhi;

      for (int i = 0; i < N; i++) mem[i] = 8'(16 * i);
      vt[0] = '{2'd0, 8'd128, 8'd0,   16'hFF00, 8, -1,  3, 19, 11};
      vt[1] = '{2'd1, 8'd128, 8'd0,   16'h00FF, 8, -1,  3, 19, 11};
      vt[2] = '{2'd2, 8'd64,  8'd160, 16'h07F0, 7, -1,  3, 19, 11};
      vt[3] = '{2'd2, 8'd200, 8'd100, 16'h0000, 0, -1,  3, 19, 11};
      vt[4] = '{2'd3, 8'd0,   8'd0,   16'hFF00, 8, 120, 21, 37, 27};

      repeat (3) @(posedge bin_clk);
      @(negedge bin_clk);
      bin_rst_n = 1'b1;
      @(negedge bin_clk);
      chk("rst_led", int'(condition_led), 0);
      chk("rst_we", int'(bin_we), 0);
      chk("rst_fg", int'(fg_count), 0);
      chk("rst_mean", int'(mean_thres), 0);
      chk("rst_paddr", int'(pixel_address), 0);
      chk("rst_baddr", int'(bin_address), 0);
      chk("rst_bdata", int'(bin_data), 0);

      // Directed table
      for (int v = 0; v < 5; v++) begin
         run_frame(vt[v].m, vt[v].lo, vt[v].hi, 0);
         chk($sformatf("t%0d_bits", v), int'(got_bits), int'(vt[v].bits));
         chk($sformatf("t%0d_fg", v), int'(fg_count), vt[v].fg);
         chk($sformatf("t%0d_writes", v), got_writes, N);
         chk($sformatf("t%0d_first_we", v), first_we, vt[v].first);
         chk($sformatf("t%0d_done", v), done_cyc, vt[v].done);
         chk($sformatf("t%0d_busy", v), busy, vt[v].done - 1);
         chk($sformatf("t%0d_leds", v), led_hist, vt[v].leds);
         chk($sformatf("t%0d_paddr_hold", v), int'(pixel_address), N - 1);
         if (vt[v].mean >= 0) chk($sformatf("t%0d_mean", v), int'(mean_thres), vt[v].mean);
      end

      // Mid-frame start pulse and input changes are ignored
      run_frame(2'd0, 8'd128, 8'd0, 8);
      chk("pert_bits", int'(got_bits), 16'hFF00);
      chk("pert_fg", int'(fg_count), 8);
      chk("pert_done", done_cyc, 19);
      chk("pert_writes", got_writes, N);

      // Restart from DONE: old fg_count held until the new frame ends
      run_frame(2'd2, 8'd64, 8'd160, 0);
      chk("rerun_fg_mid", fg_mid, 8);
      chk("rerun_bits", int'(got_bits), 16'h07F0);
      chk("rerun_fg", int'(fg_count), 7);
      chk("rerun_mean_hold", int'(mean_thres), 120);

      // Reset in the middle of a BIN pass
      bin_mode = 2'd0; thres_lo = 8'd0; bin_ctrl = 1'b1;
      @(posedge bin_clk); @(negedge bin_clk);
      bin_ctrl = 1'b0;
      repeat (7) begin @(posedge bin_clk); @(negedge bin_clk); end
      chk("pre_rst_we", int'(bin_we), 1);
      bin_rst_n = 1'b0;
      #1;
      chk("mid_rst_led", int'(condition_led), 0);
      chk("mid_rst_we", int'(bin_we), 0);
      chk("mid_rst_bdata", int'(bin_data), 0);
      chk("mid_rst_baddr", int'(bin_address), 0);
      chk("mid_rst_paddr", int'(pixel_address), 0);
      chk("mid_rst_fg", int'(fg_count), 0);
      chk("mid_rst_mean", int'(mean_thres), 0);
      repeat (2) @(posedge bin_clk);
      @(negedge bin_clk);
      bin_rst_n = 1'b1;
      got_writes = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge bin_clk);
         if (bin_we || condition_led != 2'b00) got_writes++;
      end
      chk("post_rst_idle", got_writes, 0);
      run_frame(vt[0].m, vt[0].lo, vt[0].hi, 0);
      chk("post_rst_bits", int'(got_bits), int'(vt[0].bits));
      chk("post_rst_fg", int'(fg_count), vt[0].fg);
      chk("post_rst_done", done_cyc, vt[0].done);

      // Randomized frames against the behavioural model
      exp_mean = 0;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
         rm  = 2'($urandom_range(0, 3));
         rlo = 8'($urandom_range(0, 255));
         rhi = 8'($urandom_range(0, 255));
         sum = 0;
         for (int i = 0; i < N; i++) sum += int'(mem[i]);
         if (rm == 2'd3) exp_mean = sum / N;
         exp_fg = 0;
         for (int i = 0; i < N; i++) begin
            exp_bits[i] = ref_bit(rm, int'(rlo), int'(rhi), exp_mean, int'(mem[i]));
            exp_fg += int'(exp_bits[i]);
         end
         run_frame(rm, rlo, rhi, 0);
         chk($sformatf("r%0d_bits", f), int'(got_bits), int'(exp_bits));
         chk($sformatf("r%0d_fg", f), int'(fg_count), exp_fg);
         chk($sformatf("r%0d_mean", f), int'(mean_thres), exp_mean);
         chk($sformatf("r%0d_done", f), done_cyc, (rm == 2'd3) ? 2 * N + 5 : N + 3);
         chk($sformatf("r%0d_writes", f), got_writes, N);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
